// File: rtl/overlay_pkg.sv
// Shared constants and payload type for the overlay output path.
package overlay_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned LANES    = 4;

    typedef logic [LANES*SAMPLE_W-1:0] lane_word_t;

endpackage

// File: rtl/overlay_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one wrap bit.
module overlay_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr_c;
    logic             do_rd_c;

    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd_c   = rd_en && !empty_c;
    // A write while full is allowed only when the same cycle frees a slot.
    assign do_wr_c   = wr_en && (!full_c || do_rd_c);
    assign rd_data_c = mem[rd_ptr[AW-1:0]];

    // Storage; cleared on reset so the read port shows zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (do_wr_c) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd_c) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/overlay_out_packer.sv
// Captures four I/Q lanes, packs complete sets into words and streams them framed.
module overlay_out_packer
    import overlay_pkg::*;
#(
    parameter int unsigned DATA_W     = SAMPLE_W,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic [DATA_W-1:0]         i_I0_data,
    input  logic                      i_I0_valid,
    input  logic [DATA_W-1:0]         i_Q0_data,
    input  logic                      i_Q0_valid,
    input  logic [DATA_W-1:0]         i_I1_data,
    input  logic                      i_I1_valid,
    input  logic [DATA_W-1:0]         i_Q1_data,
    input  logic                      i_Q1_valid,
    output logic [LANES*DATA_W-1:0]   m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      o_align_err,
    output logic                      o_overflow,
    output logic [15:0]               o_drop_cnt
);

    localparam int unsigned     WORD_W   = LANES * DATA_W;
    localparam int unsigned     CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [15:0]     DROP_MAX = 16'hFFFF;

    logic [LANES-1:0]  lane_vld_c;
    logic [WORD_W-1:0] lane_dat_c;
    logic [WORD_W-1:0] hold_word;
    logic [LANES-1:0]  held;
    logic              align_err;
    logic              overflow;
    logic [15:0]       drop_cnt;
    logic [CNT_W-1:0]  frame_cnt;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic              full_c;
    logic              empty_c;
    logic [WORD_W-1:0] fifo_dout_c;

    assign lane_vld_c = {i_Q1_valid, i_I1_valid, i_Q0_valid, i_I0_valid} & {LANES{i_enable}};
    assign lane_dat_c = {i_Q1_data, i_I1_data, i_Q0_data, i_I0_data};
    assign push_c     = &held;
    assign pop_c      = !empty_c && m_tready;
    assign drop_c     = push_c && full_c && !pop_c;

    // Lane capture: a strobe in the push cycle opens the next set instead of clearing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_word <= '0;
            held      <= '0;
            align_err <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (lane_vld_c[k]) begin
                    hold_word[k*DATA_W +: DATA_W] <= lane_dat_c[k*DATA_W +: DATA_W];
                    held[k]                       <= 1'b1;
                    if (held[k] && !push_c) begin
                        align_err <= 1'b1;
                    end
                end else if (push_c) begin
                    held[k] <= 1'b0;
                end
            end
        end
    end

    // Overflow flag and saturating count of sets lost to a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Word position within the frame, advanced only by accepted words.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt <= '0;
        end else if (pop_c) begin
            frame_cnt <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + CNT_W'(1);
        end
    end

    overlay_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (push_c),
        .wr_data   (hold_word),
        .rd_en     (pop_c),
        .rd_data_c (fifo_dout_c),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    assign m_tdata     = fifo_dout_c;
    assign m_tvalid    = !empty_c;
    assign m_tlast     = (frame_cnt == LAST_IDX) && !empty_c;
    assign o_align_err = align_err;
    assign o_overflow  = overflow;
    assign o_drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_overlay_out_packer.sv
// Directed bench for overlay_out_packer (FIFO_DEPTH=16, FRAME_LEN=4).
module tb_overlay_out_packer;
    import overlay_pkg::*;

    localparam int unsigned FLEN  = 4;
    localparam int unsigned DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] i0_d, q0_d, i1_d, q1_d;
    logic        i0_v, q0_v, i1_v, q1_v;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        align_err;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [15:0] i0;
        logic [15:0] q0;
        logic [15:0] i1;
        logic [15:0] q1;
        lane_word_t  word;
    } vec_t;

    vec_t vecs [8];

    overlay_out_packer #(
        .DATA_W     (16),
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FLEN)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_I0_data   (i0_d),
        .i_I0_valid  (i0_v),
        .i_Q0_data   (q0_d),
        .i_Q0_valid  (q0_v),
        .i_I1_data   (i1_d),
        .i_I1_valid  (i1_v),
        .i_Q1_data   (q1_d),
        .i_Q1_valid  (q1_v),
        .m_tdata     (tdata),
        .m_tvalid    (tvalid),
        .m_tready    (tready),
        .m_tlast     (tlast),
        .o_align_err (align_err),
        .o_overflow  (overflow),
        .o_drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_lanes(input logic [3:0] vld, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
        {q1_v, i1_v, q0_v, i0_v} = vld;
        i0_d = a;
        q0_d = b;
        i1_d = c;
        q1_d = d;
    endtask

    task automatic idle();
        {q1_v, i1_v, q0_v, i0_v} = 4'b0000;
    endtask

    task automatic set_all(input logic [15:0] base, input int s);
        set_lanes(4'b1111, base + 16'(s), base + 16'h0100 + 16'(s),
                  base + 16'h0200 + 16'(s), base + 16'h0300 + 16'(s));
    endtask

    function automatic logic [63:0] word_of(input logic [15:0] base, input int s);
        return {base + 16'h0300 + 16'(s), base + 16'h0200 + 16'(s),
                base + 16'h0100 + 16'(s), base + 16'(s)};
    endfunction

    task automatic rst_dut();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n_last;
        logic prev_stall;
        logic [63:0] prev_data;
        logic prev_last;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        enable = 1'b1;
        tready = 1'b1;
        set_lanes(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);

        vecs[0] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 64'h0300_0200_0100_0000};
        vecs[1] = '{16'h0001, 16'h0101, 16'h0201, 16'h0301, 64'h0301_0201_0101_0001};
        vecs[2] = '{16'h0002, 16'h0102, 16'h0202, 16'h0302, 64'h0302_0202_0102_0002};
        vecs[3] = '{16'h0003, 16'h0103, 16'h0203, 16'h0303, 64'h0303_0203_0103_0003};
        vecs[4] = '{16'h0004, 16'h0104, 16'h0204, 16'h0304, 64'h0304_0204_0104_0004};
        vecs[5] = '{16'h0005, 16'h0105, 16'h0205, 16'h0305, 64'h0305_0205_0105_0005};
        vecs[6] = '{16'h0006, 16'h0106, 16'h0206, 16'h0306, 64'h0306_0206_0106_0006};
        vecs[7] = '{16'h0007, 16'h0107, 16'h0207, 16'h0307, 64'h0307_0207_0107_0007};

        // Reset state
        rst_dut();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_align", 64'(align_err), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);

        // Test 1: table of full sets, one every 4 clk, 2-cycle latency
        for (int n = 0; n < 8; n++) begin
            set_lanes(4'b1111, vecs[n].i0, vecs[n].q0, vecs[n].i1, vecs[n].q1);
            tick();
            idle();
            chk($sformatf("t1_early_tvalid[%0d]", n), 64'(tvalid), 64'd0);
            tick();
            chk($sformatf("t1_tvalid[%0d]", n), 64'(tvalid), 64'd1);
            chk($sformatf("t1_tdata[%0d]", n), tdata, vecs[n].word);
            tick();
            chk($sformatf("t1_drained[%0d]", n), 64'(tvalid), 64'd0);
            tick();
        end

        // Disabled capture ignores strobes
        enable = 1'b0;
        set_all(16'h0900, 0);
        tick();
        idle();
        tick();
        tick();
        chk("en0_tvalid", 64'(tvalid), 64'd0);
        enable = 1'b1;

        // Test 2: lanes on separate cycles, tvalid at t+5
        rst_dut();
        set_lanes(4'b0001, 16'h00A0, 16'h0, 16'h0, 16'h0);
        tick();
        set_lanes(4'b0010, 16'h0, 16'h00B1, 16'h0, 16'h0);
        tick();
        set_lanes(4'b0100, 16'h0, 16'h0, 16'h00C2, 16'h0);
        tick();
        set_lanes(4'b1000, 16'h0, 16'h0, 16'h0, 16'h00D3);
        tick();
        idle();
        chk("t2_tvalid_t4", 64'(tvalid), 64'd0);
        tick();
        chk("t2_tvalid_t5", 64'(tvalid), 64'd1);
        chk("t2_tdata", tdata, 64'h00D3_00C2_00B1_00A0);
        chk("t2_align", 64'(align_err), 64'd0);
        tick();

        // Test 3: I0 re-strobed before set completes
        rst_dut();
        set_lanes(4'b0001, 16'h0011, 16'h0, 16'h0, 16'h0);
        tick();
        set_lanes(4'b0001, 16'h0022, 16'h0, 16'h0, 16'h0);
        tick();
        set_lanes(4'b1110, 16'h0, 16'h0033, 16'h0044, 16'h0055);
        tick();
        idle();
        tick();
        chk("t3_tvalid", 64'(tvalid), 64'd1);
        chk("t3_tdata", tdata, 64'h0055_0044_0033_0022);
        chk("t3_align", 64'(align_err), 64'd1);
        tick();

        // Test 4: overflow with tready low, then drain in order
        rst_dut();
        tready = 1'b0;
        for (int s = 0; s < 20; s++) begin
            set_all(16'h1000, s);
            tick();
            idle();
            tick();
        end
        tick();
        chk("t4_ovf", 64'(overflow), 64'd1);
        chk("t4_drop", 64'(drop_cnt), 64'd4);
        tready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            chk($sformatf("t4_tvalid[%0d]", s), 64'(tvalid), 64'd1);
            chk($sformatf("t4_tdata[%0d]", s), tdata, word_of(16'h1000, s));
            chk($sformatf("t4_tlast[%0d]", s), 64'(tlast), 64'((s % 4) == 3));
            tick();
        end
        chk("t4_empty", 64'(tvalid), 64'd0);
        chk("t4_drop_held", 64'(drop_cnt), 64'd4);

        // Test 5: framing under random backpressure
        rst_dut();
        idx = 0;
        n_last = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        for (int c = 0; c < 400 && idx < 10; c++) begin
            if ((c % 2) == 0 && (c / 2) < 10) begin
                set_all(16'h5000, c / 2);
            end else begin
                idle();
            end
            tready = ((c % 5) == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (prev_stall) begin
                chk($sformatf("t5_hold_data[c%0d]", c), tdata, prev_data);
                chk($sformatf("t5_hold_last[c%0d]", c), 64'(tlast), 64'(prev_last));
            end
            if (tvalid && tready) begin
                chk($sformatf("t5_tdata[%0d]", idx), tdata, word_of(16'h5000, idx));
                chk($sformatf("t5_tlast[%0d]", idx), 64'(tlast), 64'((idx % 4) == 3));
                if (tlast) n_last++;
                idx++;
            end
            prev_stall = tvalid && !tready;
            prev_data = tdata;
            prev_last = tlast;
            tick();
        end
        idle();
        chk("t5_words", 64'(idx), 64'd10);
        chk("t5_tlast_count", 64'(n_last), 64'd2);

        // Test 6: reset mid-operation with words buffered and frame in progress
        rst_dut();
        tready = 1'b0;
        for (int s = 0; s < 7; s++) begin
            set_all(16'h2000, s);
            tick();
            idle();
            tick();
        end
        set_lanes(4'b0001, 16'h0AAA, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        idle();
        chk("t6_align_pre", 64'(align_err), 64'd1);
        chk("t6_tvalid_pre", 64'(tvalid), 64'd1);
        tready = 1'b1;
        tick();
        tick();
        tready = 1'b0;
        chk("t6_tdata_pre", tdata, word_of(16'h2000, 2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_tvalid_post", 64'(tvalid), 64'd0);
        chk("t6_tlast_post", 64'(tlast), 64'd0);
        chk("t6_align_post", 64'(align_err), 64'd0);
        chk("t6_ovf_post", 64'(overflow), 64'd0);
        chk("t6_drop_post", 64'(drop_cnt), 64'd0);
        tready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            set_all(16'h3000, s);
            tick();
            idle();
            tick();
            chk($sformatf("t6_tvalid[%0d]", s), 64'(tvalid), 64'd1);
            chk($sformatf("t6_tdata[%0d]", s), tdata, word_of(16'h3000, s));
            chk($sformatf("t6_tlast[%0d]", s), 64'(tlast), 64'(s == 3));
            tick();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
